// File: rtl/axi_arb_pkg.sv
// Shared definitions for the two-master AXI-Lite arbiter: FSM state encodings and master ids.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_WR   = 2'b01,
        ARB_RD   = 2'b10
    } arb_state_t;

    localparam logic ID_DATA  = 1'b0;
    localparam logic ID_INSTR = 1'b1;

endpackage

// File: rtl/axi_lite_arb2_rr_pick2.sv
// Two-way requester pick: round-robin by ptr when rr_en, otherwise fixed priority to id 0.
module rr_pick2
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       rr_en,
    output logic       gnt_id,
    output logic       any
);

    always_comb begin
        any    = |req;
        gnt_id = ID_DATA;
        if (req == 2'b11) begin
            gnt_id = rr_en ? ptr : ID_DATA;
        end else if (req[1]) begin
            gnt_id = ID_INSTR;
        end
    end

endmodule

// File: rtl/axi_lite_arb2.sv
// Two-master to one-slave AXI-Lite arbiter; one transaction in flight, channels muxed combinationally
// to the granted master for the whole write (AW/W/B) or read (AR/R) transaction.
module axi_lite_arb2
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR_EN  = 1
) (
    input  logic                clk,
    input  logic                rst,
    // master 0 (data side)
    input  logic [ADDR_W-1:0]   s0_awaddr,
    input  logic                s0_awvalid,
    output logic                s0_awready,
    input  logic [DATA_W-1:0]   s0_wdata,
    input  logic [DATA_W/8-1:0] s0_wstrb,
    input  logic                s0_wvalid,
    output logic                s0_wready,
    output logic                s0_bvalid,
    input  logic                s0_bready,
    input  logic [ADDR_W-1:0]   s0_araddr,
    input  logic                s0_arvalid,
    output logic                s0_arready,
    output logic [DATA_W-1:0]   s0_rdata,
    output logic                s0_rvalid,
    input  logic                s0_rready,
    // master 1 (instruction side)
    input  logic [ADDR_W-1:0]   s1_awaddr,
    input  logic                s1_awvalid,
    output logic                s1_awready,
    input  logic [DATA_W-1:0]   s1_wdata,
    input  logic [DATA_W/8-1:0] s1_wstrb,
    input  logic                s1_wvalid,
    output logic                s1_wready,
    output logic                s1_bvalid,
    input  logic                s1_bready,
    input  logic [ADDR_W-1:0]   s1_araddr,
    input  logic                s1_arvalid,
    output logic                s1_arready,
    output logic [DATA_W-1:0]   s1_rdata,
    output logic                s1_rvalid,
    input  logic                s1_rready,
    // downstream slave port
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_rvalid,
    output logic                m_rready,
    output logic                busy_o,
    output logic                grant_o
);

    arb_state_t state_q, state_d;
    logic       grant_q, grant_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic       pick_id, pick_any, win_aw;
    logic       wr_st, rd_st;

    rr_pick2 u_pick (
        .req    ({s1_awvalid | s1_arvalid, s0_awvalid | s0_arvalid}),
        .ptr    (rr_ptr_q),
        .rr_en  (RR_EN != 0),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    // a write from the winner beats its own read; the read stays asserted for the next round
    assign win_aw = (pick_id == ID_INSTR) ? s1_awvalid : s0_awvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= ID_DATA;
            rr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_id;
                    state_d = win_aw ? ARB_WR : ARB_RD;
                end
            end
            ARB_WR: begin
                if (m_bvalid && m_bready) begin
                    state_d = ARB_IDLE;
                    if (RR_EN != 0) rr_ptr_d = ~grant_q;
                end
            end
            ARB_RD: begin
                if (m_rvalid && m_rready) begin
                    state_d = ARB_IDLE;
                    if (RR_EN != 0) rr_ptr_d = ~grant_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign wr_st   = (state_q == ARB_WR);
    assign rd_st   = (state_q == ARB_RD);
    assign busy_o  = (state_q != ARB_IDLE);
    assign grant_o = grant_q;

    // everything not on the granted master's active channel is held at zero
    always_comb begin
        m_awaddr   = '0;
        m_awvalid  = 1'b0;
        m_wdata    = '0;
        m_wstrb    = '0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        m_araddr   = '0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        s0_awready = 1'b0;
        s0_wready  = 1'b0;
        s0_bvalid  = 1'b0;
        s0_arready = 1'b0;
        s0_rdata   = '0;
        s0_rvalid  = 1'b0;
        s1_awready = 1'b0;
        s1_wready  = 1'b0;
        s1_bvalid  = 1'b0;
        s1_arready = 1'b0;
        s1_rdata   = '0;
        s1_rvalid  = 1'b0;
        if (wr_st) begin
            if (grant_q == ID_INSTR) begin
                m_awaddr   = s1_awaddr;
                m_awvalid  = s1_awvalid;
                m_wdata    = s1_wdata;
                m_wstrb    = s1_wstrb;
                m_wvalid   = s1_wvalid;
                m_bready   = s1_bready;
                s1_awready = m_awready;
                s1_wready  = m_wready;
                s1_bvalid  = m_bvalid;
            end else begin
                m_awaddr   = s0_awaddr;
                m_awvalid  = s0_awvalid;
                m_wdata    = s0_wdata;
                m_wstrb    = s0_wstrb;
                m_wvalid   = s0_wvalid;
                m_bready   = s0_bready;
                s0_awready = m_awready;
                s0_wready  = m_wready;
                s0_bvalid  = m_bvalid;
            end
        end
        if (rd_st) begin
            if (grant_q == ID_INSTR) begin
                m_araddr   = s1_araddr;
                m_arvalid  = s1_arvalid;
                m_rready   = s1_rready;
                s1_arready = m_arready;
                s1_rdata   = m_rdata;
                s1_rvalid  = m_rvalid;
            end else begin
                m_araddr   = s0_araddr;
                m_arvalid  = s0_arvalid;
                m_rready   = s0_rready;
                s0_arready = m_arready;
                s0_rdata   = m_rdata;
                s0_rvalid  = m_rvalid;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_arb2.sv
// Directed bench for axi_lite_arb2: a round-robin instance and a fixed-priority instance share stimulus.
module tb_axi_lite_arb2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s0_awaddr, s0_wdata, s0_araddr, s1_awaddr, s1_wdata, s1_araddr, m_rdata;
    logic [3:0]  s0_wstrb, s1_wstrb;
    logic        s0_awvalid, s0_wvalid, s0_bready, s0_arvalid, s0_rready;
    logic        s1_awvalid, s1_wvalid, s1_bready, s1_arvalid, s1_rready;
    logic        m_awready, m_wready, m_bvalid, m_arready, m_rvalid;

    // round-robin instance outputs
    logic        s0_awready, s0_wready, s0_bvalid, s0_arready, s0_rvalid;
    logic        s1_awready, s1_wready, s1_bvalid, s1_arready, s1_rvalid;
    logic [31:0] s0_rdata, s1_rdata, m_awaddr, m_wdata, m_araddr;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, busy_o, grant_o;

    // fixed-priority instance outputs
    logic        f_s0_awready, f_s0_wready, f_s0_bvalid, f_s0_arready, f_s0_rvalid;
    logic        f_s1_awready, f_s1_wready, f_s1_bvalid, f_s1_arready, f_s1_rvalid;
    logic [31:0] f_s0_rdata, f_s1_rdata, f_m_awaddr, f_m_wdata, f_m_araddr;
    logic [3:0]  f_m_wstrb;
    logic        f_m_awvalid, f_m_wvalid, f_m_bready, f_m_arvalid, f_m_rready, f_busy_o, f_grant_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_lite_arb2 #(.ADDR_W(32), .DATA_W(32), .RR_EN(1)) dut (
        .clk(clk), .rst(rst),
        .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
        .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
        .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rdata(s0_rdata), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
        .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
        .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rdata(s1_rdata), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .busy_o(busy_o), .grant_o(grant_o)
    );

    axi_lite_arb2 #(.ADDR_W(32), .DATA_W(32), .RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid), .s0_awready(f_s0_awready),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(f_s0_wready),
        .s0_bvalid(f_s0_bvalid), .s0_bready(s0_bready),
        .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(f_s0_arready),
        .s0_rdata(f_s0_rdata), .s0_rvalid(f_s0_rvalid), .s0_rready(s0_rready),
        .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(f_s1_awready),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(f_s1_wready),
        .s1_bvalid(f_s1_bvalid), .s1_bready(s1_bready),
        .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(f_s1_arready),
        .s1_rdata(f_s1_rdata), .s1_rvalid(f_s1_rvalid), .s1_rready(s1_rready),
        .m_awaddr(f_m_awaddr), .m_awvalid(f_m_awvalid), .m_awready(m_awready),
        .m_wdata(f_m_wdata), .m_wstrb(f_m_wstrb), .m_wvalid(f_m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(f_m_bready),
        .m_araddr(f_m_araddr), .m_arvalid(f_m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(f_m_rready),
        .busy_o(f_busy_o), .grant_o(f_grant_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s0_awaddr = '0; s0_awvalid = 0; s0_wdata = '0; s0_wstrb = '0; s0_wvalid = 0; s0_bready = 0;
        s0_araddr = '0; s0_arvalid = 0; s0_rready = 0;
        s1_awaddr = '0; s1_awvalid = 0; s1_wdata = '0; s1_wstrb = '0; s1_wvalid = 0; s1_bready = 0;
        s1_araddr = '0; s1_arvalid = 0; s1_rready = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // reset state, stray B response in idle is not forwarded
        do_reset();
        m_bvalid = 1; m_rvalid = 1; #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_rrptr", dut.rr_ptr_q, 0);
        chk("rst_awvalid", m_awvalid, 0);
        chk("rst_awaddr", m_awaddr, 0);
        chk("rst_s0_awready", s0_awready, 0);
        chk("idle_s0_bvalid", s0_bvalid, 0);
        chk("idle_s0_rvalid", s0_rvalid, 0);
        chk("rst_s0_rdata", s0_rdata, 0);
        m_bvalid = 0; m_rvalid = 0;

        // single write from s0
        do_reset();
        s0_awaddr = 32'h1000_0004; s0_awvalid = 1; s0_wdata = 32'hDEAD_BEEF; s0_wstrb = 4'hF;
        s0_wvalid = 1; s0_bready = 1; #1;
        chk("wr_c0_awvalid", m_awvalid, 0);
        tick();
        chk("wr_c1_awvalid", m_awvalid, 1);
        chk("wr_c1_awaddr", m_awaddr, 32'h1000_0004);
        chk("wr_c1_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("wr_c1_wstrb", m_wstrb, 4'hF);
        chk("wr_c1_busy", busy_o, 1);
        chk("wr_c1_grant", grant_o, 0);
        chk("wr_c1_arvalid", m_arvalid, 0);
        chk("wr_c1_s0_awready", s0_awready, 0);
        tick();
        m_awready = 1; m_wready = 1; #1;
        chk("wr_c2_s0_awready", s0_awready, 1);
        chk("wr_c2_s0_wready", s0_wready, 1);
        chk("wr_c2_s1_awready", s1_awready, 0);
        chk("wr_c2_s1_wready", s1_wready, 0);
        tick();
        s0_awvalid = 0; s0_wvalid = 0; m_awready = 0; m_wready = 0; #1;
        chk("wr_c3_busy", busy_o, 1);
        chk("wr_c3_s0_bvalid", s0_bvalid, 0);
        tick();
        m_bvalid = 1; #1;
        chk("wr_c4_s0_bvalid", s0_bvalid, 1);
        chk("wr_c4_s1_bvalid", s1_bvalid, 0);
        chk("wr_c4_bready", m_bready, 1);
        tick();
        m_bvalid = 0; #1;
        chk("wr_c5_busy", busy_o, 0);
        chk("wr_c5_s0_bvalid", s0_bvalid, 0);
        chk("wr_c5_rrptr", dut.rr_ptr_q, 1);

        // simultaneous reads, round-robin from rr_ptr=0
        do_reset();
        s0_araddr = 32'h100; s0_arvalid = 1; s0_rready = 1;
        s1_araddr = 32'h200; s1_arvalid = 1; s1_rready = 1;
        tick();
        m_arready = 1; #1;
        chk("rd_a_grant", grant_o, 0);
        chk("rd_a_araddr", m_araddr, 32'h100);
        chk("rd_a_arvalid", m_arvalid, 1);
        chk("rd_a_s0_arready", s0_arready, 1);
        chk("rd_a_s1_arready", s1_arready, 0);
        tick();
        s0_arvalid = 0; m_arready = 0; m_rvalid = 1; m_rdata = 32'hAAAA_0001; #1;
        chk("rd_a_s0_rvalid", s0_rvalid, 1);
        chk("rd_a_s0_rdata", s0_rdata, 32'hAAAA_0001);
        chk("rd_a_s1_rvalid", s1_rvalid, 0);
        chk("rd_a_s1_rdata", s1_rdata, 0);
        tick();
        m_rvalid = 0; #1;
        chk("rd_gap_busy", busy_o, 0);
        chk("rd_gap_arvalid", m_arvalid, 0);
        tick();
        m_arready = 1; #1;
        chk("rd_b_grant", grant_o, 1);
        chk("rd_b_araddr", m_araddr, 32'h200);
        chk("rd_b_s1_arready", s1_arready, 1);
        tick();
        s1_arvalid = 0; m_arready = 0; m_rvalid = 1; m_rdata = 32'hBBBB_0002; #1;
        chk("rd_b_s1_rdata", s1_rdata, 32'hBBBB_0002);
        chk("rd_b_s0_rdata", s0_rdata, 0);
        tick();
        m_rvalid = 0; #1;
        chk("rd_b_busy_end", busy_o, 0);

        // both request continuously: fixed priority keeps s0, round-robin alternates
        do_reset();
        s0_araddr = 32'h10; s0_arvalid = 1; s0_rready = 1;
        s1_araddr = 32'h20; s1_arvalid = 1; s1_rready = 1;
        m_arready = 1; m_rvalid = 1; m_rdata = 32'h5555_AAAA;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fp_busy%0d", k), f_busy_o, 1);
            chk($sformatf("fp_grant%0d", k), f_grant_o, 0);
            chk($sformatf("rr_grant%0d", k), grant_o, k % 2);
            tick();
            chk($sformatf("fp_gap%0d", k), f_busy_o, 0);
        end
        s0_arvalid = 0;
        tick();
        chk("fp_s1_grant", f_grant_o, 1);
        chk("fp_s1_araddr", f_m_araddr, 32'h20);
        chk("fp_s0_arready", f_s0_arready, 0);

        // write beats read from the same master
        do_reset();
        s1_awaddr = 32'h400; s1_awvalid = 1; s1_wdata = 32'h0BAD_F00D; s1_wstrb = 4'h1; s1_wvalid = 1;
        s1_bready = 1; s1_araddr = 32'h300; s1_arvalid = 1; s1_rready = 1;
        tick();
        m_arready = 1; m_awready = 1; m_wready = 1; m_bvalid = 1; #1;
        chk("wor_grant", grant_o, 1);
        chk("wor_awvalid", m_awvalid, 1);
        chk("wor_awaddr", m_awaddr, 32'h400);
        chk("wor_arvalid", m_arvalid, 0);
        chk("wor_s1_arready", s1_arready, 0);
        chk("wor_s1_awready", s1_awready, 1);
        tick();
        s1_awvalid = 0; s1_wvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0; #1;
        chk("wor_gap_busy", busy_o, 0);
        tick();
        chk("wor_rd_arvalid", m_arvalid, 1);
        chk("wor_rd_araddr", m_araddr, 32'h300);
        chk("wor_rd_awvalid", m_awvalid, 0);
        chk("wor_rd_s1_arready", s1_arready, 1);
        tick();
        s1_arvalid = 0; m_arready = 0; m_rvalid = 1; #1;
        chk("wor_rd_s1_rvalid", s1_rvalid, 1);
        tick();
        m_rvalid = 0; #1;
        chk("wor_end_busy", busy_o, 0);

        // slow slave on the write channels
        do_reset();
        s0_awaddr = 32'h2000; s0_awvalid = 1; s0_wdata = 32'h1234_5678; s0_wstrb = 4'h3;
        s0_wvalid = 1; s0_bready = 1;
        tick();
        chk("slow_c1_awready", s0_awready, 0);
        tick();
        chk("slow_c2_wready", s0_wready, 0);
        tick();
        m_awready = 1; #1;
        chk("slow_c3_awready", s0_awready, 1);
        chk("slow_c3_wready", s0_wready, 0);
        tick();
        s0_awvalid = 0; m_awready = 0; #1;
        chk("slow_c4_awvalid", m_awvalid, 0);
        chk("slow_c4_wvalid", m_wvalid, 1);
        tick();
        m_wready = 1; #1;
        chk("slow_c5_wready", s0_wready, 1);
        chk("slow_c5_awready", s0_awready, 0);
        tick();
        s0_wvalid = 0; m_wready = 0; m_rvalid = 1; #1;
        chk("slow_c6_busy", busy_o, 1);
        chk("slow_c6_s0_rvalid", s0_rvalid, 0);
        tick();
        m_rvalid = 0; m_bvalid = 1; #1;
        chk("slow_c7_busy", busy_o, 1);
        chk("slow_c7_s0_bvalid", s0_bvalid, 1);
        tick();
        m_bvalid = 0; #1;
        chk("slow_end_busy", busy_o, 0);
        chk("slow_end_rrptr", dut.rr_ptr_q, 1);

        // reset while a read from s1 waits on a stalled R channel
        s1_araddr = 32'h800; s1_arvalid = 1; s1_rready = 1;
        tick();
        m_arready = 1; #1;
        chk("rrst_grant", grant_o, 1);
        tick();
        s1_arvalid = 0; m_arready = 0; #1;
        chk("rrst_busy", busy_o, 1);
        chk("rrst_rready", m_rready, 1);
        rst = 1'b1;
        tick();
        chk("rrst_busy_after", busy_o, 0);
        chk("rrst_arvalid_after", m_arvalid, 0);
        chk("rrst_rready_after", m_rready, 0);
        chk("rrst_grant_after", grant_o, 0);
        chk("rrst_rrptr_after", dut.rr_ptr_q, 0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_arb2.md
Name: axi_lite_arb2

Overview:
- Two-master to one-slave AXI-Lite arbiter.
- Lets the data-side and instruction-side AXI-Lite bus interfaces of the MIPS32 core share the single SoC AXI-Lite interconnect port.
- One transaction outstanding at a time. Grant is held from arbitration until the B or R handshake completes.
- Address, data and response channels are passed through combinationally to the granted master.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; strobe width is DATA_W/8
RR_EN, 1, 1 = round-robin between s0/s1; 0 = fixed priority, s0 always wins

Ports:
clk  input  1  clock
rst  input  1  reset
sN_awaddr (N=0 data, N=1 instr)  input  ADDR_W  write address from master N
sN_awvalid  input  1  write address valid from master N
sN_awready  output  1  write address ready to master N
sN_wdata  input  DATA_W  write data from master N
sN_wstrb  input  DATA_W/8  write byte strobes from master N
sN_wvalid  input  1  write data valid from master N
sN_wready  output  1  write data ready to master N
sN_bvalid  output  1  write response valid to master N
sN_bready  input  1  write response ready from master N
sN_araddr  input  ADDR_W  read address from master N
sN_arvalid  input  1  read address valid from master N
sN_arready  output  1  read address ready to master N
sN_rdata  output  DATA_W  read data to master N
sN_rvalid  output  1  read data valid to master N
sN_rready  input  1  read data ready from master N
m_awaddr/m_awvalid/m_awready, m_wdata/m_wstrb/m_wvalid/m_wready, m_bvalid/m_bready, m_araddr/m_arvalid/m_arready, m_rdata/m_rvalid/m_rready  same widths, opposite directions  downstream slave port
busy_o  output  1  transaction in flight (state != ARB_IDLE)
grant_o  output  1  id of the granted master; valid while busy_o=1

Behaviour:
- Reset is synchronous, active-high on rst. Clock is clk.
- Reset values:
  - state=ARB_IDLE, grant=0, rr_ptr=0.
  - All m_*valid, m_*ready, sN_*ready and sN_*valid = 0.
  - m_* address/data buses = 0. sN_rdata = 0.
- States:
  - ARB_IDLE: nothing passed through. All valids and readies are driven 0.
  - ARB_WR: AW, W and B channels connect the granted master to m_.
  - ARB_RD: AR and R channels connect the granted master to m_.
- Request: reqN = sN_awvalid | sN_arvalid, sampled in ARB_IDLE only.
- Winner when both masters request:
  - RR_EN=1: the master selected by rr_ptr.
  - RR_EN=0: s0.
- Winner when only one master requests: that master.
- Within the winner, a write (awvalid) takes precedence over a read (arvalid). The read stays pending for the next arbitration.
- ARB_IDLE -> ARB_WR or ARB_RD on the clk edge where any reqN=1. grant is registered on the same edge.
- Latency: m_awvalid/m_arvalid rises exactly 1 cycle after the requester's valid is first seen in ARB_IDLE.
- ARB_WR exits to ARB_IDLE on the edge where m_bvalid & m_bready.
- ARB_RD exits to ARB_IDLE on the edge where m_rvalid & m_rready.
- On exit, rr_ptr <= ~grant (RR_EN=1 only).
- After every transaction there is at least 1 ARB_IDLE cycle, so back-to-back grants are never issued.
- Pass-through is combinational with zero added latency. AW/W valid and ready are forwarded independently. The arbiter does not reorder or buffer.
- Non-granted master: all its readies and valids are 0, and its requests are held off.
- Non-selected channel of the granted master (AR/R in ARB_WR, AW/W/B in ARB_RD): its readies and valids are 0.
- An m_bvalid or m_rvalid arriving in ARB_IDLE, or on the wrong channel, is ignored and never forwarded.
- Reset mid-transaction: returns to ARB_IDLE on the next edge and all outputs drop. Recovery of the in-flight slave transaction is not attempted and is out of scope.
- Fairness: with RR_EN=1 and both masters continuously requesting, grants alternate s0, s1, s0, ...

Decomposition:
- Package axi_arb_pkg holds:
  - state encodings ARB_IDLE=2'b00, ARB_WR=2'b01, ARB_RD=2'b10
  - master ids ID_DATA=0, ID_INSTR=1
- One sub-module, rr_pick2: inputs req[1:0], ptr, rr_en; outputs gnt_id and any.
- The top level holds the FSM, the grant/rr_ptr registers and the channel muxes.

Test Plan:
- Single write: s0 awaddr=0x1000_0004, wdata=0xDEAD_BEEF, wstrb=4'hF; slave readies asserted in cycle 2, B in cycle 4. Required: m_awvalid=1 one cycle after s0_awvalid; m_awaddr/m_wdata match; s0_bvalid pulses once; busy_o falls the cycle after B; s1 sees no readies.
- Simultaneous reads: s0 araddr=0x100, s1 araddr=0x200, RR_EN=1, rr_ptr=0. Required: s0 granted first (grant_o=0); after its R handshake, 1 idle cycle, then grant_o=1 and m_araddr=0x200; s0_rdata/s1_rdata carry the respective slave responses.
- Fixed priority: RR_EN=0, both masters request 3 times back-to-back. Required: all s0 transactions complete before any s1 grant.
- Write-over-read: s1 asserts awvalid and arvalid together. Required: ARB_WR first, then ARB_RD for the held read.
- Slow slave: AWREADY in cycle 3, WREADY in cycle 5. Required: s0_awready and s0_wready mirror the slave exactly; no early exit before B.
- Reset during ARB_RD, with the slave stalling R. Required: on the next edge busy_o=0, m_arvalid=0, m_rready=0, grant_o=0, rr_ptr=0.
